// File: rtl/mbist_mbisr_engine.sv
// mbist_mbisr_engine: March C- / MATS+ memory BIST with spare-row repair
// (BISR) and a user port that shares the repair remap once the engine is idle.
// Optional build macro MBIST_ERR_COUNT_EN enables a saturating miscompare
// counter on err_count; without it err_count is tied to zero.
//
// Control handshake: start is a one-cycle request, accepted only in IDLE or
// DONE (ignored while busy). busy is high from the cycle after acceptance to
// the end of the last pass; done is a level held in DONE until the next
// accepted start or reset, and fail/repair_cnt are valid whenever done=1.
module mbist_mbisr_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SPARES = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            mode,
  output logic                            busy,
  output logic                            done,
  output logic                            fail,
  output logic [$clog2(NUM_SPARES+1)-1:0] repair_cnt,
  output logic [15:0]                     err_count,
  input  logic                            usr_en,
  input  logic                            usr_we,
  input  logic [ADDR_WIDTH-1:0]           usr_addr,
  input  logic [DATA_WIDTH-1:0]           usr_wdata,
  output logic [DATA_WIDTH-1:0]           usr_rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [2:0]                      dbg_state
);
  localparam int CW         = $clog2(NUM_SPARES+1);
  localparam int USER_DEPTH = (1 << ADDR_WIDTH) - NUM_SPARES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(USER_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] SPARE_BASE = ADDR_WIDTH'(USER_DEPTH);
  localparam logic [CW-1:0]         SPARES_MAX = CW'(NUM_SPARES);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_ISSUE, S_RD_CMP, S_ELEM_NEXT, S_PASS_END, S_DONE
  } state_t;

  // One March element: optional read of rd_val, optional write of wr_val,
  // walked descending when down=1.
  typedef struct packed {
    logic rd;
    logic rd_val;
    logic wr;
    logic wr_val;
    logic down;
  } elem_t;

  typedef logic [NUM_SPARES-1:0][ADDR_WIDTH-1:0] tbl_t;

  // Element table; bit order {rd, rd_val, wr, wr_val, down}.
  function automatic elem_t elem_desc(input logic m, input logic [2:0] idx);
    elem_t d;
    d = '0;
    if (m) begin
      case (idx)
        3'd0:    d = elem_t'(5'b00100);  // w0
        3'd1:    d = elem_t'(5'b10110);  // up (r0,w1)
        3'd2:    d = elem_t'(5'b11101);  // down (r1,w0)
        default: d = '0;
      endcase
    end else begin
      case (idx)
        3'd0:    d = elem_t'(5'b00100);  // w0
        3'd1:    d = elem_t'(5'b10110);  // up (r0,w1)
        3'd2:    d = elem_t'(5'b11100);  // up (r1,w0)
        3'd3:    d = elem_t'(5'b10111);  // down (r0,w1)
        3'd4:    d = elem_t'(5'b11101);  // down (r1,w0)
        3'd5:    d = elem_t'(5'b10000);  // r0
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  // Logical -> physical address; addresses outside the user range pass through.
  function automatic logic [ADDR_WIDTH-1:0] remap(input logic [ADDR_WIDTH-1:0] a,
                                                  input tbl_t t,
                                                  input logic [CW-1:0] n);
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    for (int i = 0; i < NUM_SPARES; i++) begin
      if ((i < int'(n)) && (t[i] == a) && (a <= LAST_ADDR)) r = ADDR_WIDTH'(USER_DEPTH + i);
    end
    return r;
  endfunction

  state_t                state;
  logic                  mode_q;
  logic                  pass2;
  logic                  ovf;
  logic [2:0]            elem;
  logic [ADDR_WIDTH-1:0] addr;
  tbl_t                  tbl;
  logic                  bist_en;
  logic                  bist_we;
  logic [ADDR_WIDTH-1:0] bist_addr;
  logic [DATA_WIDTH-1:0] bist_wdata;

  elem_t                 cur;
  logic [2:0]            elem_end;
  logic                  addr_last;
  logic [ADDR_WIDTH-1:0] addr_adv;
  logic [ADDR_WIDTH-1:0] addr_first;
  logic                  miscmp;
  logic                  hit;
  logic                  alloc;
  logic                  user_sel;
  logic                  usr_go;

  // Decode of the current element, address stepping and compare result.
  always_comb begin
    cur        = elem_desc(mode_q, elem);
    elem_end   = mode_q ? 3'd3 : 3'd6;
    addr_last  = cur.down ? (addr == '0) : (addr == LAST_ADDR);
    addr_adv   = cur.down ? (addr - 1'b1) : (addr + 1'b1);
    addr_first = cur.down ? LAST_ADDR : '0;
    miscmp     = (state == S_RD_CMP) && (mem_rdata != {DATA_WIDTH{cur.rd_val}});
    hit        = 1'b0;
    for (int i = 0; i < NUM_SPARES; i++) begin
      if ((i < int'(repair_cnt)) && (tbl[i] == addr)) hit = 1'b1;
    end
    alloc      = miscmp && !pass2 && !hit && (repair_cnt < SPARES_MAX);
  end

  // Main sequencer: March walk, repair allocation and pass decisions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      pass2      <= 1'b0;
      ovf        <= 1'b0;
      elem       <= '0;
      addr       <= '0;
      tbl        <= '0;
      repair_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      bist_en    <= 1'b0;
      bist_we    <= 1'b0;
      bist_addr  <= '0;
      bist_wdata <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_WR;
            mode_q     <= mode;
            pass2      <= 1'b0;
            ovf        <= 1'b0;
            elem       <= '0;
            addr       <= '0;
            tbl        <= '0;
            repair_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            bist_en    <= 1'b1;
            bist_we    <= 1'b1;
            bist_addr  <= '0;
            bist_wdata <= '0;
          end
        end
        S_WR: begin
          if (addr_last) begin
            state   <= S_ELEM_NEXT;
            elem    <= elem + 3'd1;
            bist_en <= 1'b0;
            bist_we <= 1'b0;
          end else begin
            state      <= cur.rd ? S_RD_ISSUE : S_WR;
            addr       <= addr_adv;
            bist_en    <= 1'b1;
            bist_we    <= !cur.rd;
            bist_addr  <= remap(addr_adv, tbl, repair_cnt);
            bist_wdata <= {DATA_WIDTH{cur.wr_val}};
          end
        end
        S_RD_ISSUE: begin
          state   <= S_RD_CMP;
          bist_en <= 1'b0;
        end
        S_RD_CMP: begin
          if (miscmp) begin
            if (pass2) fail <= 1'b1;
            else if (!hit && !alloc) ovf <= 1'b1;
          end
          if (alloc) begin
            for (int i = 0; i < NUM_SPARES; i++) begin
              if (i == int'(repair_cnt)) tbl[i] <= addr;
            end
            repair_cnt <= repair_cnt + 1'b1;
          end
          if (cur.wr) begin
            // A freshly allocated spare takes the write that follows the read.
            state      <= S_WR;
            bist_en    <= 1'b1;
            bist_we    <= 1'b1;
            bist_addr  <= alloc ? (SPARE_BASE + ADDR_WIDTH'(repair_cnt))
                                : remap(addr, tbl, repair_cnt);
            bist_wdata <= {DATA_WIDTH{cur.wr_val}};
          end else if (addr_last) begin
            state <= S_ELEM_NEXT;
            elem  <= elem + 3'd1;
          end else begin
            state     <= S_RD_ISSUE;
            addr      <= addr_adv;
            bist_en   <= 1'b1;
            bist_we   <= 1'b0;
            bist_addr <= remap(addr_adv, tbl, repair_cnt);
          end
        end
        S_ELEM_NEXT: begin
          // elem already points at the following element here.
          if (elem == elem_end) begin
            state <= S_PASS_END;
          end else begin
            state      <= cur.rd ? S_RD_ISSUE : S_WR;
            addr       <= addr_first;
            bist_en    <= 1'b1;
            bist_we    <= !cur.rd;
            bist_addr  <= remap(addr_first, tbl, repair_cnt);
            bist_wdata <= {DATA_WIDTH{cur.wr_val}};
          end
        end
        S_PASS_END: begin
          if (!pass2 && !ovf && (repair_cnt != '0)) begin
            state      <= S_WR;
            pass2      <= 1'b1;
            elem       <= '0;
            addr       <= '0;
            bist_en    <= 1'b1;
            bist_we    <= 1'b1;
            bist_addr  <= remap('0, tbl, repair_cnt);
            bist_wdata <= '0;
          end else begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            bist_addr  <= '0;
            bist_wdata <= '0;
            if (ovf) fail <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MBIST_ERR_COUNT_EN
  logic [15:0] err_q;

  // Saturating miscompare counter across both passes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= '0;
    end else if (((state == S_IDLE) || (state == S_DONE)) && start) begin
      err_q <= '0;
    end else if (miscmp && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'd0;
`endif

  // User port owns the memory only when idle and no start is being accepted.
  assign user_sel  = ((state == S_IDLE) || (state == S_DONE)) && !start && rst;
  assign usr_go    = user_sel && usr_en;
  assign mem_en    = user_sel ? usr_en : bist_en;
  assign mem_we    = user_sel ? (usr_en & usr_we) : bist_we;
  assign mem_addr  = usr_go ? remap(usr_addr, tbl, repair_cnt) : bist_addr;
  assign mem_wdata = usr_go ? usr_wdata : bist_wdata;
  assign usr_rdata = mem_rdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_mbist_mbisr_engine.sv
// tb_mbist_mbisr_engine: table-driven bench for mbist_mbisr_engine with a
// 16x8 memory model carrying per-address stuck-at faults.
module tb_mbist_mbisr_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       busy, done, fail;
  logic [2:0] repair_cnt;
  logic [15:0] err_count;
  logic       usr_en = 1'b0;
  logic       usr_we = 1'b0;
  logic [3:0] usr_addr = 4'd0;
  logic [7:0] usr_wdata = 8'd0;
  logic [7:0] usr_rdata;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Memory model state and fault masks.
  logic [7:0]  mem [16];
  logic [15:0] sa0_map = '0;
  logic [7:0]  sa0_bits = '0;
  logic [15:0] sa1_map = '0;
  logic [7:0]  sa1_bits = '0;

  typedef struct {
    logic        mode;
    logic [15:0] sa0_map;
    logic [7:0]  sa0_bits;
    logic [15:0] sa1_map;
    logic [7:0]  sa1_bits;
    logic        exp_fail;
    int          exp_cnt;
    int          exp_busy;
    int          exp_err;
  } vec_t;

  vec_t vecs [7];

  mbist_mbisr_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_SPARES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .fail(fail),
    .repair_cnt(repair_cnt), .err_count(err_count),
    .usr_en(usr_en), .usr_we(usr_we), .usr_addr(usr_addr),
    .usr_wdata(usr_wdata), .usr_rdata(usr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] flt(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (sa0_map[a]) r = r & ~sa0_bits;
    if (sa1_map[a]) r = r | sa1_bits;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= flt(mem_addr, mem[mem_addr]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start, then count busy cycles until the engine drops busy.
  task automatic run_test(input logic m, output int n);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_err(input string name, input int exp);
`ifdef MBIST_ERR_COUNT_EN
    chk(name, 32'(err_count), 32'(exp));
`else
    chk(name, 32'(err_count), 32'd0);
`endif
  endtask

  initial begin
    int n;
    // {mode, sa0_map, sa0_bits, sa1_map, sa1_bits, fail, cnt, busy, err}
    vecs[0] = '{1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0, 0, 187, 0};
    vecs[1] = '{1'b0, 16'h02A6, 8'h01, 16'h0000, 8'h00, 1'b1, 4, 187, 6};
    vecs[2] = '{1'b0, 16'h0020, 8'h01, 16'h1000, 8'h01, 1'b1, 1, 374, 6};
    vecs[3] = '{1'b1, 16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0, 0, 88,  0};
    vecs[4] = '{1'b1, 16'h0008, 8'h01, 16'h0000, 8'h00, 1'b0, 1, 176, 1};
    vecs[5] = '{1'b0, 16'h0000, 8'h00, 16'h0001, 8'h80, 1'b0, 1, 374, 1};
    vecs[6] = '{1'b0, 16'h0008, 8'h01, 16'h0000, 8'h00, 1'b0, 1, 374, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_cnt", 32'(repair_cnt), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int i = 0; i < 7; i++) begin
      sa0_map  = vecs[i].sa0_map;
      sa0_bits = vecs[i].sa0_bits;
      sa1_map  = vecs[i].sa1_map;
      sa1_bits = vecs[i].sa1_bits;
      run_test(vecs[i].mode, n);
      chk($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_fail", i), 32'(fail), 32'(vecs[i].exp_fail));
      chk($sformatf("v%0d_repair_cnt", i), 32'(repair_cnt), 32'(vecs[i].exp_cnt));
      check_err($sformatf("v%0d_err_count", i), vecs[i].exp_err);
    end

    // User path through the repair of address 3 (last vector left it mapped to 12)
    @(negedge clk);
    usr_en = 1'b1; usr_we = 1'b1; usr_addr = 4'd3; usr_wdata = 8'hA5;
    #1;
    chk("usr_wr_en", 32'(mem_en), 32'd1);
    chk("usr_wr_we", 32'(mem_we), 32'd1);
    chk("usr_wr_addr", 32'(mem_addr), 32'd12);
    chk("usr_wr_data", 32'(mem_wdata), 32'hA5);
    @(negedge clk);
    usr_we = 1'b0; usr_addr = 4'd3;
    exp_q.push_back(8'hA5);
    #1;
    chk("usr_rd_addr", 32'(mem_addr), 32'd12);
    chk("usr_rd_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("usr_rd_data3", 32'(usr_rdata), 32'(exp_q.pop_front()));
    // Unrepaired address: last BIST write to 4 was all zeros
    usr_addr = 4'd4;
    exp_q.push_back(8'h00);
    #1;
    chk("usr_addr4", 32'(mem_addr), 32'd4);
    @(negedge clk);
    chk("usr_rd_data4", 32'(usr_rdata), 32'(exp_q.pop_front()));
    // Beyond user depth passes straight through
    usr_we = 1'b1; usr_addr = 4'd13; usr_wdata = 8'h5A;
    #1;
    chk("usr_addr13", 32'(mem_addr), 32'd13);
    @(negedge clk);
    usr_we = 1'b0;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    usr_en = 1'b0;
    chk("usr_rd_data13", 32'(usr_rdata), 32'(exp_q.pop_front()));

    // Start and usr_en together: access dropped; later start/user ignored while busy
    sa0_map = '0; sa1_map = '0;
    @(negedge clk);
    mode = 1'b0; start = 1'b1;
    usr_en = 1'b1; usr_we = 1'b1; usr_addr = 4'd4; usr_wdata = 8'h3C;
    #1;
    chk("start_wins_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    start = 1'b0; usr_en = 1'b0; usr_we = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      start  = (n == 50);
      usr_en = (n == 60);
      usr_we = (n == 60);
      @(negedge clk);
    end
    start = 1'b0; usr_en = 1'b0; usr_we = 1'b0;
    chk("busy_ignore_cycles", 32'(n), 32'd187);
    chk("busy_ignore_fail", 32'(fail), 32'd0);
    chk("busy_ignore_cnt", 32'(repair_cnt), 32'd0);

    // Reset mid pass 1, then a clean run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    rst = 1'b1;
    run_test(1'b0, n);
    chk("post_rst_cycles", 32'(n), 32'd187);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_fail", 32'(fail), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mbist_mbisr_engine.md
Name: mbist_mbisr_engine

Overview:
- Parametrised successor of the fixed 8x256 BIST/BISR integration.
- Runs a selectable March algorithm (March C- or MATS+) on an external single-port memory.
- Allocates spare rows for failing addresses, then reruns the test with remapping active to confirm the repair.
- Once idle, a user port reaches the memory through the same repair remap.

Parameters:
- ADDR_WIDTH, 8: physical address width; physical depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: memory word width.
- NUM_SPARES, 16: spare rows at the top of the array; legal range 1..2**(ADDR_WIDTH-1). USER_DEPTH = 2**ADDR_WIDTH - NUM_SPARES.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- mode  input  1  0 = March C-, 1 = MATS+; latched on accepted start.
- busy  output  1  high while a test pass runs.
- done  output  1  level; high in DONE until next accepted start or reset.
- fail  output  1  valid when done: unrepairable or retest miscompare.
- repair_cnt  output  $clog2(NUM_SPARES+1)  spares allocated.
- err_count  output  16  miscompare count (see Optional Feature).
- usr_en, usr_we  input  1 each  user access strobe and write enable.
- usr_addr  input  ADDR_WIDTH  logical user address.
- usr_wdata  input  DATA_WIDTH  user write data.
- usr_rdata  output  DATA_WIDTH  equals mem_rdata.
- mem_en, mem_we  output  1 each  memory strobe and write enable.
- mem_addr  output  ADDR_WIDTH  physical address after remap.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  valid the cycle after mem_en=1 with mem_we=0.

Behaviour:
- Reset:
  - busy, done, fail, repair_cnt, err_count, mem_en, mem_we, mem_addr, mem_wdata = 0.
  - Repair table cleared; state IDLE.
  - Reset mid-run aborts the run; mem_en=0 from the next cycle.
- States: IDLE, WR, RD_ISSUE, RD_CMP, ELEM_NEXT, PASS_END, DONE.
- Accepted start: clears the repair table, repair_cnt, err_count, fail, done; enters pass 1.
- Start is ignored while busy.
- Algorithms ("0" = all zeros, "1" = all ones):
  - March C-: up/down(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up/down(r0). up/down elements run ascending.
  - MATS+: (w0); up(r0,w1); down(r1,w0).
- Only logical addresses 0..USER_DEPTH-1 are walked.
- Op timing:
  - write = 1 cycle (WR).
  - read = 2 cycles (RD_ISSUE, then RD_CMP compares mem_rdata with expected).
  - ELEM_NEXT = 1 cycle.
  - pass length = K*USER_DEPTH + E cycles; K=15/E=6 for March C-, K=7/E=3 for MATS+.
- Remap: mem_addr = USER_DEPTH + i if table entry i is valid and matches the logical address; otherwise the logical address.
- Remap applies to all BIST accesses in both passes and to all user accesses.
- Pass 1 miscompare:
  - Address already in table: no action.
  - Otherwise, if repair_cnt < NUM_SPARES: write to entry repair_cnt, increment repair_cnt.
  - Otherwise: set the internal overflow flag.
  - The pass continues to completion in all cases.
- PASS_END after pass 1:
  - repair_cnt=0 and no overflow: DONE, fail=0.
  - overflow: DONE, fail=1.
  - else: run pass 2.
- Pass 2: any miscompare sets fail=1; no table updates; DONE at pass end.
- IDLE/DONE, user path:
  - mem_en=usr_en, mem_we=usr_we, mem_addr=remap(usr_addr), mem_wdata=usr_wdata.
  - usr_addr >= USER_DEPTH is passed through unremapped.
- User port is ignored while busy.
- Start and usr_en in the same cycle: start wins; the user access is dropped.

Optional Feature:
- Macro: MBIST_ERR_COUNT_EN.
- Defined: err_count is a 16-bit counter that increments on every miscompare in either pass and saturates at 0xFFFF. Cleared on reset and on accepted start.
- Undefined: err_count is tied to 0 and no counter logic exists.

Test Plan:
All cases use ADDR_WIDTH=4, DATA_WIDTH=8, NUM_SPARES=4 (USER_DEPTH=12) unless stated.
- Fault-free memory, mode=0, start pulse -> busy for exactly 1 pass (15*12+6 cycles plus entry/exit); done=1, fail=0, repair_cnt=0; err_count=0 with MBIST_ERR_COUNT_EN.
- Bit0 stuck-at-0 at address 3, mode=0 -> done=1, fail=0, repair_cnt=1. Then usr write 0xA5 to 3 -> mem_addr=12, mem_wdata=0xA5; usr read 3 returns 0xA5 next cycle.
- Faults at addresses 1,2,5,7,9 -> overflow; done=1, fail=1, repair_cnt=4, no pass 2 (busy ends after one pass).
- Fault at address 5 plus stuck-at-1 in spare row 12 -> pass 2 miscompares; done=1, fail=1, repair_cnt=1.
- mode=1, fault-free -> pass length 7*12+3 cycles; done=1, fail=0.
- rst=0 asserted mid pass 1, then released -> next cycle all outputs 0 and mem_en=0; a new start runs cleanly to done=1, fail=0.
